// File: rtl/snake_body_tracker.sv
// Snake state owner: head, heading, length and segment array; moves one cell per tick
// and flags apple eats (goodColl pulse) and deaths (sticky badColl).
module snake_body_tracker #(
  parameter int unsigned MAX_LEN   = 50,
  parameter int unsigned GRID_BITS = 4,
  parameter int unsigned INIT_LEN  = 3,
  parameter bit          WALL_WRAP = 1'b0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              tick,
  input  logic [1:0]                        dir,
  input  logic [2*GRID_BITS-1:0]            apple_cord,
  output logic [2*GRID_BITS-1:0]            body [MAX_LEN],
  output logic [$clog2(MAX_LEN+1)-1:0]      length,
  output logic [2*GRID_BITS-1:0]            head,
  output logic                              goodColl,
  output logic                              badColl
);

  localparam int unsigned CW = 2 * GRID_BITS;
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t          state, state_nx;
  logic [1:0]      heading;
  logic [1:0]      mv_dir;
  logic            move, grow, off_grid, self_hit, fatal, legal;
  logic [GRID_BITS-1:0] cx, cy, nx, ny;
  logic [CW-1:0]   nh;
  logic [LW-1:0]   len_nx;
  logic [CW-1:0]   body_nx [MAX_LEN];

  assign head = body[0];

  // Next-state, move evaluation and next body image
  always_comb begin
    state_nx = state;
    move     = (state == RUN) && tick;
    // The exact reverse of the current heading flips only the low bit
    mv_dir   = (dir == {heading[1], ~heading[0]}) ? heading : dir;
    cx       = body[0][CW-1:GRID_BITS];
    cy       = body[0][GRID_BITS-1:0];
    nx       = cx;
    ny       = cy;
    off_grid = 1'b0;
    case (mv_dir)
      2'b00: begin ny = cy - GRID_BITS'(1); off_grid = (cy == '0); end
      2'b01: begin ny = cy + GRID_BITS'(1); off_grid = (cy == '1); end
      2'b10: begin nx = cx - GRID_BITS'(1); off_grid = (cx == '0); end
      default: begin nx = cx + GRID_BITS'(1); off_grid = (cx == '1); end
    endcase
    nh   = {nx, ny};
    grow = (nh == apple_cord);

    // Tail slot counts as occupied only when the snake is growing
    self_hit = 1'b0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if ((body[i] == nh) &&
          ((LW'(i) < length - LW'(1)) || (grow && (LW'(i) == length - LW'(1)))))
        self_hit = 1'b1;
    end

    fatal  = move && ((off_grid && !WALL_WRAP) || self_hit);
    legal  = move && !fatal;
    len_nx = (grow && (length < LW'(MAX_LEN))) ? length + LW'(1) : length;

    body_nx = body;
    if (legal) begin
      body_nx[0] = nh;
      for (int i = 1; i < int'(MAX_LEN); i++)
        body_nx[i] = (LW'(i) < len_nx) ? body[i-1] : body[len_nx - LW'(2)];
    end

    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (fatal) state_nx = DEAD;
      default: state_nx = DEAD;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      heading  <= 2'b11;
      length   <= LW'(INIT_LEN);
      goodColl <= 1'b0;
      badColl  <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++)
        body[i] <= {GRID_BITS'(5 - ((i < int'(INIT_LEN)) ? i : int'(INIT_LEN) - 1)),
                    GRID_BITS'(5)};
    end else begin
      state    <= state_nx;
      goodColl <= legal && grow;
      badColl  <= badColl | fatal;
      if (legal) begin
        heading <= mv_dir;
        length  <= len_nx;
        body    <= body_nx;
      end
    end
  end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Bench for snake_body_tracker: directed scenarios plus random play against a
// queue-based snake model.
module tb_snake_body_tracker;

  localparam int MAX_LEN = 50;
  localparam int GB      = 4;
  localparam bit WRAP    = 1'b0;

  logic       clk = 1'b0;
  logic       reset, start, tick;
  logic [1:0] dir;
  logic [7:0] apple_cord;
  logic [7:0] body [MAX_LEN];
  logic [5:0] length;
  logic [7:0] head;
  logic       goodColl, badColl;

  int checks = 0;
  int errors = 0;

  // Model: snake as a queue of coordinates, head at the front
  int m_q[$];
  int m_hd;
  int m_st;   // 0 idle, 1 run, 2 dead
  bit m_good, m_bad;

  snake_body_tracker #(.MAX_LEN(MAX_LEN), .GRID_BITS(GB), .INIT_LEN(3), .WALL_WRAP(WRAP)) dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .dir(dir),
    .apple_cord(apple_cord), .body(body), .length(length), .head(head),
    .goodColl(goodColl), .badColl(badColl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_reverse(input int h, input int d);
    return (h == 0 && d == 1) || (h == 1 && d == 0) || (h == 2 && d == 3) || (h == 3 && d == 2);
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 3; i++) m_q.push_back(((5 - i) << 4) | 5);
    m_hd = 3; m_st = 0; m_good = 0; m_bad = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit t, input int d, input int ap);
    int h, x, y, nx, ny, nh;
    bit off, grow, hit, keep;
    if (!r) begin
      model_reset();
      return;
    end
    m_good = 0;
    if (m_st == 0) begin
      if (s) m_st = 1;
    end else if (m_st == 1 && t) begin
      h  = is_reverse(m_hd, d) ? m_hd : d;
      x  = m_q[0] >> 4;
      y  = m_q[0] & 15;
      nx = x + ((h == 3) ? 1 : (h == 2) ? -1 : 0);
      ny = y + ((h == 1) ? 1 : (h == 0) ? -1 : 0);
      off = (nx < 0) || (nx > 15) || (ny < 0) || (ny > 15);
      nh  = ((nx & 15) << 4) | (ny & 15);
      grow = (nh == ap);
      hit  = 0;
      for (int i = 0; i < m_q.size() - 1; i++) if (m_q[i] == nh) hit = 1;
      if (grow && m_q[m_q.size()-1] == nh) hit = 1;
      if ((off && !WRAP) || hit) begin
        m_st = 2; m_bad = 1;
      end else begin
        keep = grow && (m_q.size() < MAX_LEN);
        m_hd = h;
        m_q.push_front(nh);
        if (!keep) void'(m_q.pop_back());
        m_good = grow;
      end
    end
  endtask

  task automatic compare_all();
    int n;
    n = m_q.size();
    check("head", 32'(head), 32'(m_q[0]));
    check("length", 32'(length), 32'(n));
    check("goodColl", 32'(goodColl), 32'(m_good));
    check("badColl", 32'(badColl), 32'(m_bad));
    for (int i = 0; i < MAX_LEN; i++)
      check($sformatf("body[%0d]", i), 32'(body[i]), 32'((i < n) ? m_q[i] : m_q[n-1]));
  endtask

  task automatic cycle(input bit r, input bit s, input bit t, input logic [1:0] d, input logic [7:0] ap);
    reset = r; start = s; tick = t; dir = d; apple_cord = ap;
    @(posedge clk);
    model_step(r, s, t, int'(d), int'(ap));
    #1;
    compare_all();
  endtask

  task automatic restart();
    cycle(1'b0, 1'b0, 1'b0, 2'b11, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 2'b11, 8'h00);
  endtask

  function automatic logic [7:0] step_of(input int c, input int d);
    int x, y;
    x = c >> 4; y = c & 15;
    case (d)
      0: y = y - 1;
      1: y = y + 1;
      2: x = x - 1;
      default: x = x + 1;
    endcase
    return 8'(((x & 15) << 4) | (y & 15));
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; tick = 1'b0; dir = 2'b11; apple_cord = 8'h00;

    // Reset values and basic movement
    cycle(1'b0, 1'b0, 1'b0, 2'b11, 8'h00);
    check("rst_head", 32'(head), 32'h55);
    check("rst_slot49", 32'(body[49]), 32'h35);
    cycle(1'b1, 1'b0, 1'b1, 2'b11, 8'h00);   // idle tick ignored
    cycle(1'b1, 1'b1, 1'b1, 2'b11, 8'h00);   // start+tick: no move
    check("start_tick_head", 32'(head), 32'h55);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 2'b11, 8'h00);
    check("t1_head", 32'(head), 32'h85);
    check("t1_body2", 32'(body[2]), 32'h65);
    check("t1_len", 32'(length), 32'd3);

    // Eat an apple
    restart();
    cycle(1'b1, 1'b0, 1'b1, 2'b11, 8'h65);
    check("t2_good", 32'(goodColl), 32'd1);
    check("t2_len", 32'(length), 32'd4);
    check("t2_body3", 32'(body[3]), 32'h35);
    cycle(1'b1, 1'b0, 1'b0, 2'b11, 8'h65);
    check("t2_good_off", 32'(goodColl), 32'd0);

    // Reverse request ignored
    restart();
    cycle(1'b1, 1'b0, 1'b1, 2'b10, 8'h00);
    check("t3_head_a", 32'(head), 32'h65);
    cycle(1'b1, 1'b0, 1'b1, 2'b00, 8'h00);
    check("t3_head_b", 32'(head), 32'h64);

    // Wall death, frozen, reset recovers
    restart();
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 1'b1, 2'b11, 8'h00);
    check("t4_head_edge", 32'(head), 32'hf5);
    cycle(1'b1, 1'b0, 1'b1, 2'b11, 8'h00);
    check("t4_bad", 32'(badColl), 32'd1);
    check("t4_head_frozen", 32'(head), 32'hf5);
    cycle(1'b1, 1'b1, 1'b1, 2'b01, 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 2'b00, 8'h00);
    check("t4_still_dead", 32'(badColl), 32'd1);
    restart();
    check("t4_recover", 32'(badColl), 32'd0);

    // Tail chase at length 4 survives
    restart();
    cycle(1'b1, 1'b0, 1'b1, 2'b11, 8'h65);
    cycle(1'b1, 1'b0, 1'b1, 2'b01, 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 2'b10, 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 2'b00, 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 2'b11, 8'h00);
    check("t5_len4_alive", 32'(badColl), 32'd0);
    // Same loop at length 5 dies
    restart();
    cycle(1'b1, 1'b0, 1'b1, 2'b11, 8'h65);
    cycle(1'b1, 1'b0, 1'b1, 2'b11, 8'h75);
    cycle(1'b1, 1'b0, 1'b1, 2'b01, 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 2'b10, 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 2'b00, 8'h00);
    check("t5_len5_dead", 32'(badColl), 32'd1);

    // Reset on a tick that would eat
    restart();
    cycle(1'b1, 1'b0, 1'b1, 2'b11, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 2'b11, 8'h75);
    check("t6_head", 32'(head), 32'h55);
    check("t6_len", 32'(length), 32'd3);
    check("t6_good", 32'(goodColl), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 2'b11, 8'h65);   // back in IDLE: no move
    check("t6_idle", 32'(head), 32'h55);

    // Random play
    restart();
    for (int k = 0; k < 1500; k++) begin
      logic [1:0] d;
      logic [7:0] ap;
      bit r, s, t;
      d  = 2'($urandom_range(0, 3));
      ap = ($urandom_range(0, 1) == 1) ? step_of(m_q[0], int'($urandom_range(0, 3)))
                                       : 8'($urandom);
      r  = !(($urandom_range(0, 99) == 0) || (m_st == 2 && $urandom_range(0, 9) == 0));
      s  = ($urandom_range(0, 19) == 0) || (m_st == 0 && $urandom_range(0, 3) == 0);
      t  = ($urandom_range(0, 9) < 5);
      cycle(r, s, t, d, ap);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
